// File: rtl/bcd_scan_display.sv
`default_nettype none
// ============================================================================
// Module   : bcd_scan_display
// Brief    : Handshaked binary-to-BCD (double-dabble) converter driving a
//            time-multiplexed common-anode seven-segment display.
// Revision : 1.0 - initial release
// ============================================================================
module bcd_scan_display #(
  parameter int BIN_W    = 16,
  parameter int DIGITS   = 4,
  parameter int SIGNED   = 0,
  parameter int BLANK_LZ = 1,
  parameter int SCAN_DIV = 131072
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [BIN_W-1:0]  bin,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              done,
  input  logic [DIGITS-1:0] dp_mask,
  input  logic              blank,
  output logic [6:0]        seg,
  output logic              dp,
  output logic [DIGITS-1:0] an
);

  function automatic int calc_nib(input int w);
    logic [63:0] v;
    int          n;
    v = (64'd1 << w) - 64'd1;
    n = 0;
    for (int k = 0; k < 20; k++) begin
      if (v != 64'd0) begin
        v = v / 64'd10;
        n = n + 1;
      end
    end
    return n;
  endfunction

  localparam int NIB  = calc_nib(BIN_W);
  localparam int NPAD = (NIB > DIGITS) ? NIB : DIGITS;
  localparam int CW   = $clog2(BIN_W);
  localparam int SW   = $clog2(SCAN_DIV);
  localparam int IW   = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  localparam logic [6:0] c_seg_off  = 7'b1111111;
  localparam logic [6:0] c_seg_dash = 7'b0111111;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SHIFT  = 2'd1,
    S_COMMIT = 2'd2
  } state_t;

  state_t             r_state;
  logic               r_ready;
  logic               r_done;
  logic [CW-1:0]      r_cnt;
  logic [BIN_W-1:0]   r_mag;
  logic               r_neg;
  logic [4*NIB-1:0]   r_bcd;
  logic [4*NIB-1:0]   r_disp_bcd;
  logic               r_disp_neg;
  logic               r_disp_ovf;
  logic [SW-1:0]      r_scan;
  logic [IW-1:0]      r_idx;
  logic [6:0]         r_seg;
  logic               r_dp;
  logic [DIGITS-1:0]  r_an;

  logic               w_neg;
  logic [BIN_W-1:0]   w_mag;
  logic [4*NIB-1:0]   w_add;
  logic [4*NIB-1:0]   w_bcd_nxt;
  logic               w_ovf;
  logic [4*NPAD-1:0]  w_pad;
  logic [3:0]         w_dig [DIGITS];
  logic [DIGITS-1:0]  w_lzb;
  logic [6:0]         w_seg;
  logic               w_dp;
  logic [DIGITS-1:0]  w_an;

  // Two's complement taken as unsigned so the most negative value still converts.
  assign w_neg = (SIGNED != 0) && bin[BIN_W-1];
  assign w_mag = w_neg ? (~bin + 1'b1) : bin;

  always_comb begin
    w_add = r_bcd;
    for (int k = 0; k < NIB; k++) begin
      if (w_add[4*k +: 4] >= 4'd5) w_add[4*k +: 4] = w_add[4*k +: 4] + 4'd3;
    end
    w_bcd_nxt = (w_add << 1) | {{(4*NIB-1){1'b0}}, r_mag[BIN_W-1]};
  end

  always_comb begin
    w_ovf = 1'b0;
    for (int k = 0; k < NIB; k++) begin
      if ((k >= (r_neg ? DIGITS - 1 : DIGITS)) && (w_bcd_nxt[4*k +: 4] != 4'd0)) w_ovf = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_ready    <= 1'b1;
      r_done     <= 1'b0;
      r_cnt      <= '0;
      r_mag      <= '0;
      r_neg      <= 1'b0;
      r_bcd      <= '0;
      r_disp_bcd <= '0;
      r_disp_neg <= 1'b0;
      r_disp_ovf <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_mag   <= w_mag;
            r_neg   <= w_neg;
            r_bcd   <= '0;
            r_cnt   <= '0;
            r_ready <= 1'b0;
            r_state <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          r_bcd <= w_bcd_nxt;
          r_mag <= r_mag << 1;
          r_cnt <= r_cnt + 1'b1;
          // Final shift: publish digits, sign and overflow together.
          if (r_cnt == CW'(BIN_W - 1)) begin
            r_disp_bcd <= w_bcd_nxt;
            r_disp_neg <= r_neg;
            r_disp_ovf <= w_ovf;
            r_done     <= 1'b1;
            r_state    <= S_COMMIT;
          end
        end
        S_COMMIT: begin
          r_ready <= 1'b1;
          r_state <= S_IDLE;
        end
        default: begin
          r_ready <= 1'b1;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  generate
    if (NPAD > NIB) begin : g_pad
      assign w_pad = {{(4*(NPAD-NIB)){1'b0}}, r_disp_bcd};
    end else begin : g_nopad
      assign w_pad = r_disp_bcd;
    end
  endgenerate

  generate
    for (genvar i = 0; i < DIGITS; i++) begin : g_digit
      assign w_dig[i] = w_pad[4*i +: 4];
      if (i == 0) begin : g_lsd
        assign w_lzb[i] = 1'b0;
      end else begin : g_upper
        assign w_lzb[i] = (BLANK_LZ != 0) && (w_pad[4*NPAD-1:4*i] == '0);
      end
    end
  endgenerate

  function automatic logic [6:0] seg_decode(input logic [3:0] n);
    case (n)
      4'd0:    return 7'b1000000;
      4'd1:    return 7'b1111001;
      4'd2:    return 7'b0100100;
      4'd3:    return 7'b0110000;
      4'd4:    return 7'b0011001;
      4'd5:    return 7'b0010010;
      4'd6:    return 7'b0000010;
      4'd7:    return 7'b1111000;
      4'd8:    return 7'b0000000;
      4'd9:    return 7'b0011000;
      default: return 7'b1111111;
    endcase
  endfunction

  always_comb begin
    w_seg = c_seg_off;
    w_dp  = 1'b1;
    w_an  = '1;
    if (!blank) begin
      w_an = ~(DIGITS'(1) << r_idx);
      w_dp = ~dp_mask[r_idx];
      if (r_disp_ovf)                                  w_seg = c_seg_dash;
      else if (r_disp_neg && (r_idx == IW'(DIGITS-1))) w_seg = c_seg_dash;
      else if (w_lzb[r_idx])                           w_seg = c_seg_off;
      else                                             w_seg = seg_decode(w_dig[r_idx]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_scan <= '0;
      r_idx  <= '0;
      r_seg  <= c_seg_off;
      r_dp   <= 1'b1;
      r_an   <= '1;
    end else begin
      if (r_scan == SW'(SCAN_DIV - 1)) begin
        r_scan <= '0;
        r_idx  <= (r_idx == IW'(DIGITS - 1)) ? '0 : r_idx + 1'b1;
      end else begin
        r_scan <= r_scan + 1'b1;
      end
      r_seg <= w_seg;
      r_dp  <= w_dp;
      r_an  <= w_an;
    end
  end

  assign in_ready = r_ready;
  assign done     = r_done;
  assign seg      = r_seg;
  assign dp       = r_dp;
  assign an       = r_an;

endmodule
`default_nettype wire

// File: tb/tb_bcd_scan_display.sv
`default_nettype none
// ============================================================================
// Module   : tb_bcd_scan_display
// Brief    : Directed self-checking bench for bcd_scan_display (unsigned and
//            signed instances sharing one stimulus stream).
// Revision : 1.0 - initial release
// ============================================================================
module tb_bcd_scan_display;

  localparam logic [6:0] c_s0   = 7'b1000000;
  localparam logic [6:0] c_s1   = 7'b1111001;
  localparam logic [6:0] c_s2   = 7'b0100100;
  localparam logic [6:0] c_s3   = 7'b0110000;
  localparam logic [6:0] c_s4   = 7'b0011001;
  localparam logic [6:0] c_s7   = 7'b1111000;
  localparam logic [6:0] c_dash = 7'b0111111;
  localparam logic [6:0] c_off  = 7'b1111111;

  logic        clk      = 1'b0;
  logic        rst      = 1'b1;
  logic        in_valid = 1'b0;
  logic        blank    = 1'b0;
  logic [15:0] bin      = '0;
  logic [3:0]  dp_mask  = '0;

  logic       rdy_u, done_u, dp_u, rdy_s, done_s, dp_s;
  logic [6:0] seg_u, seg_s;
  logic [3:0] an_u, an_s;

  int n_assert = 0;
  int n_fail   = 0;

  logic [6:0] cap_seg [4];
  logic       cap_dp  [4];

  always #5 clk = ~clk;

  bcd_scan_display #(.BIN_W(16), .DIGITS(4), .SIGNED(0), .BLANK_LZ(1), .SCAN_DIV(4)) u_dut_u (
    .clk(clk), .rst(rst), .bin(bin), .in_valid(in_valid), .in_ready(rdy_u), .done(done_u),
    .dp_mask(dp_mask), .blank(blank), .seg(seg_u), .dp(dp_u), .an(an_u)
  );

  bcd_scan_display #(.BIN_W(16), .DIGITS(4), .SIGNED(1), .BLANK_LZ(1), .SCAN_DIV(4)) u_dut_s (
    .clk(clk), .rst(rst), .bin(bin), .in_valid(in_valid), .in_ready(rdy_s), .done(done_s),
    .dp_mask(dp_mask), .blank(blank), .seg(seg_s), .dp(dp_s), .an(an_s)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One full rotation (4 digits x 4 cycles) records what each digit shows.
  task automatic capture(input bit sgn);
    logic [3:0] seen;
    logic [3:0] a;
    logic [3:0] m;
    seen = '0;
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      a = sgn ? an_s : an_u;
      for (int d = 0; d < 4; d++) begin
        m = 4'b0001 << d;
        if (a == ~m) begin
          cap_seg[d] = sgn ? seg_s : seg_u;
          cap_dp[d]  = sgn ? dp_s : dp_u;
          seen[d]    = 1'b1;
        end
      end
    end
    check("scan_all_digits", {28'd0, seen}, 32'hF);
  endtask

  task automatic check_digits(input string tag, input bit sgn,
                              input logic [6:0] e3, input logic [6:0] e2,
                              input logic [6:0] e1, input logic [6:0] e0);
    capture(sgn);
    check({tag, "_d0"}, {25'd0, cap_seg[0]}, {25'd0, e0});
    check({tag, "_d1"}, {25'd0, cap_seg[1]}, {25'd0, e1});
    check({tag, "_d2"}, {25'd0, cap_seg[2]}, {25'd0, e2});
    check({tag, "_d3"}, {25'd0, cap_seg[3]}, {25'd0, e3});
  endtask

  task automatic convert(input logic [15:0] v, input bit sgn);
    int k;
    @(negedge clk);
    check("ready_before_accept", {31'd0, sgn ? rdy_s : rdy_u}, 32'd1);
    bin      = v;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    k = 1;
    check("ready_low_busy", {31'd0, sgn ? rdy_s : rdy_u}, 32'd0);
    while (!(sgn ? done_s : done_u) && k < 40) begin
      @(negedge clk);
      k++;
    end
    check("done_latency", k, 32'd17);
    @(negedge clk);
    check("done_one_cycle", {31'd0, sgn ? done_s : done_u}, 32'd0);
    check("ready_after_commit", {31'd0, sgn ? rdy_s : rdy_u}, 32'd1);
  endtask

  initial begin
    int dones;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ready", {31'd0, rdy_u}, 32'd1);
    check("rst_done", {31'd0, done_u}, 32'd0);
    check("rst_seg", {25'd0, seg_u}, 32'h7F);
    check("rst_dp", {31'd0, dp_u}, 32'd1);
    check("rst_an", {28'd0, an_u}, 32'hF);

    // First cycle after release drives digit 0, then rotates every 4 cycles
    rst = 1'b0;
    @(negedge clk);
    check("rel_seg", {25'd0, seg_u}, {25'd0, c_s0});
    check("rot_an0", {28'd0, an_u}, 32'hE);
    repeat (4) @(negedge clk);
    check("rot_an1", {28'd0, an_u}, 32'hD);
    repeat (4) @(negedge clk);
    check("rot_an2", {28'd0, an_u}, 32'hB);
    repeat (4) @(negedge clk);
    check("rot_an3", {28'd0, an_u}, 32'h7);
    repeat (4) @(negedge clk);
    check("rot_wrap", {28'd0, an_u}, 32'hE);
    check_digits("zero", 1'b0, c_off, c_off, c_off, c_s0);

    // Unsigned values, overflow, leading-zero blanking
    convert(16'd1234, 1'b0);
    check_digits("v1234", 1'b0, c_s1, c_s2, c_s3, c_s4);
    convert(16'd10000, 1'b0);
    check_digits("v10000", 1'b0, c_dash, c_dash, c_dash, c_dash);
    convert(16'd7, 1'b0);
    check_digits("v7", 1'b0, c_off, c_off, c_off, c_s7);

    // Signed instance
    convert(16'hFF85, 1'b1);
    check_digits("m123", 1'b1, c_dash, c_s1, c_s2, c_s3);
    convert(16'hFC18, 1'b1);
    check_digits("m1000", 1'b1, c_dash, c_dash, c_dash, c_dash);
    convert(16'h8000, 1'b1);
    check_digits("m32768", 1'b1, c_dash, c_dash, c_dash, c_dash);
    convert(16'd42, 1'b1);
    check_digits("p42", 1'b1, c_off, c_off, c_s4, c_s2);

    // in_valid while busy is dropped
    @(negedge clk);
    bin      = 16'd1234;
    in_valid = 1'b1;
    @(negedge clk);
    bin   = 16'd5678;
    dones = 0;
    @(negedge clk);
    in_valid = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (done_u) dones++;
    end
    check("busy_single_done", dones, 32'd1);
    dp_mask = 4'b0010;
    check_digits("busy", 1'b0, c_s1, c_s2, c_s3, c_s4);
    check("dp_d0", {31'd0, cap_dp[0]}, 32'd1);
    check("dp_d1", {31'd0, cap_dp[1]}, 32'd0);
    check("dp_d2", {31'd0, cap_dp[2]}, 32'd1);
    check("dp_d3", {31'd0, cap_dp[3]}, 32'd1);
    dp_mask = 4'b0000;

    // Reset in the middle of a conversion
    @(negedge clk);
    bin      = 16'd999;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    dones    = 0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_mid_ready", {31'd0, rdy_u}, 32'd1);
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (done_u) dones++;
    end
    check("rst_mid_no_done", dones, 32'd0);
    check_digits("rst_mid", 1'b0, c_off, c_off, c_off, c_s0);

    // Blank input
    blank = 1'b1;
    @(negedge clk);
    check("blank_an", {28'd0, an_u}, 32'hF);
    check("blank_seg", {25'd0, seg_u}, 32'h7F);
    blank = 1'b0;
    @(negedge clk);
    check("unblank_onehot", $countones(~an_u), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
